// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: host-to-device command sequencer for a PS/2 keyboard port.
// Sends LED update (0xED + LED byte) and keyboard reset (0xFF), consumes
// the 0xFA/0xFE replies from the scancode receiver, forwards everything else.
//
// Ports:
//   clk, rst            system clock, async active-high reset
//   ps2_clk_in/data_in  raw PS/2 lines (synchronized here)
//   ps2_clk_oe/data_oe  1 = pull the corresponding PS/2 line low
//   rx_key, rx_valid    scancode receiver byte and valid level
//   leds                {caps, num, scroll}
//   led_req/kbd_rst_req one-cycle command requests
//   busy                command in progress or pending
//   key, key_valid      forwarded scancode and one-cycle strobe
//   err                 sticky, last command failed
//
// state      | meaning
// IDLE       | lines released, waiting for a pending request
// INHIBIT    | clock held low before request-to-send
// REQ        | clock released, start bit on data
// SEND       | shift data/parity/stop on device clock falls, sample line-ack
// WAIT_REPLY | wait for 0xFA/0xFE from the receiver
`timescale 1ns/1ps
module ps2_cmd_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 2400,
  parameter int unsigned TIMEOUT_CYCLES = 480000,
  parameter int unsigned GUARD_CYCLES   = 2048,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_key,
  input  logic       rx_valid,
  input  logic [2:0] leds,
  input  logic       led_req,
  input  logic       kbd_rst_req,
  output logic       busy,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       err
);

  localparam int unsigned TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_REPLY} state_t;

  state_t        state;
  logic [1:0]    clk_sync, dat_sync, rxv_sync;
  logic          clk_prev, rxv_prev;
  logic          fe, rxe;
  logic          rst_pend, led_pend;
  logic [7:0]    seq0, seq1, cur_byte;
  logic          two_bytes, byte_idx;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic [GW-1:0] guard_cnt;
  logic [RW-1:0] retry_cnt;
  logic          rx_take, send_fail, reply_ok, reply_fail, fail;

  assign fe   = clk_prev & ~clk_sync[1];
  assign rxe  = rxv_sync[1] & ~rxv_prev;
  assign busy = (state != IDLE) | rst_pend | led_pend;

  always_comb begin
    cur_byte   = byte_idx ? seq1 : seq0;
    rx_take    = rxe && (guard_cnt == '0);
    send_fail  = (state == SEND) && (fe ? (bit_cnt == 4'd10 && dat_sync[1]) : (timer == '0));
    reply_ok   = (state == WAIT_REPLY) && rx_take && (rx_key == 8'hFA);
    reply_fail = (state == WAIT_REPLY) && !reply_ok &&
                 ((rx_take && rx_key == 8'hFE) || (timer == '0));
    fail       = send_fail | reply_fail;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_sync    <= 2'b11;
      dat_sync    <= 2'b11;
      rxv_sync    <= 2'b00;
      clk_prev    <= 1'b1;
      rxv_prev    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      key         <= 8'h00;
      key_valid   <= 1'b0;
      err         <= 1'b0;
      rst_pend    <= 1'b0;
      led_pend    <= 1'b0;
      seq0        <= 8'h00;
      seq1        <= 8'h00;
      two_bytes   <= 1'b0;
      byte_idx    <= 1'b0;
      bit_cnt     <= '0;
      timer       <= '0;
      guard_cnt   <= '0;
      retry_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      dat_sync  <= {dat_sync[0], ps2_data_in};
      rxv_sync  <= {rxv_sync[0], rx_valid};
      clk_prev  <= clk_sync[1];
      rxv_prev  <= rxv_sync[1];
      key_valid <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (rxe) begin
            key       <= rx_key;
            key_valid <= 1'b1;
          end
          if (rst_pend || led_pend) begin
            if (rst_pend) begin
              rst_pend  <= 1'b0;
              seq0      <= 8'hFF;
              seq1      <= 8'h00;
              two_bytes <= 1'b0;
            end else begin
              led_pend  <= 1'b0;
              seq0      <= 8'hED;
              seq1      <= {5'b0, leds};
              two_bytes <= 1'b1;
            end
            err        <= 1'b0;
            byte_idx   <= 1'b0;
            retry_cnt  <= '0;
            timer      <= TW'(INHIBIT_CYCLES - 1);
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (rxe) begin
            key       <= rx_key;
            key_valid <= 1'b1;
          end
          if (timer == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state       <= REQ;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        REQ: begin
          bit_cnt <= '0;
          timer   <= TW'(TIMEOUT_CYCLES - 1);
          state   <= SEND;
        end
        SEND: begin
          if (fe) begin
            bit_cnt <= bit_cnt + 1'b1;
            timer   <= TW'(TIMEOUT_CYCLES - 1);
            if (bit_cnt < 4'd8)
              ps2_data_oe <= ~cur_byte[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8)
              ps2_data_oe <= ^cur_byte;  // inverse of the odd-parity bit
            else if (bit_cnt == 4'd9)
              ps2_data_oe <= 1'b0;
            else if (!dat_sync[1]) begin
              guard_cnt <= GW'(GUARD_CYCLES);
              state     <= WAIT_REPLY;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        WAIT_REPLY: begin
          if (guard_cnt != '0) guard_cnt <= guard_cnt - 1'b1;
          timer <= timer - 1'b1;
          if (reply_ok) begin
            if (two_bytes && !byte_idx) begin
              byte_idx   <= 1'b1;
              retry_cnt  <= '0;
              timer      <= TW'(INHIBIT_CYCLES - 1);
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end else begin
              state <= IDLE;
            end
          end else if (rx_take && rx_key != 8'hFE) begin
            key       <= rx_key;
            key_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Any failure resends the current byte until the retry budget is spent.
      if (fail) begin
        ps2_data_oe <= 1'b0;
        if (retry_cnt == RW'(MAX_RETRY)) begin
          err        <= 1'b1;
          ps2_clk_oe <= 1'b0;
          state      <= IDLE;
        end else begin
          retry_cnt  <= retry_cnt + 1'b1;
          timer      <= TW'(INHIBIT_CYCLES - 1);
          ps2_clk_oe <= 1'b1;
          state      <= INHIBIT;
        end
      end

      // Placed last so a request in the accepting cycle is not lost.
      if (kbd_rst_req) rst_pend <= 1'b1;
      if (led_req)     led_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed testbench for ps2_cmd_ctrl with a behavioural keyboard that
// clocks host frames, optionally line-acks, and replies through the
// receiver-side rx_key/rx_valid interface.
`timescale 1ns/1ps
module tb_ps2_cmd_ctrl;
  localparam int INH = 2400;
  localparam int TMO = 3000;
  localparam int GRD = 200;
  localparam int MR  = 3;
  localparam int H   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_clk_pull = 1'b0, kbd_data_pull = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] rx_key = 8'h00;
  logic       rx_valid = 1'b0;
  logic [2:0] leds = 3'b000;
  logic       led_req = 1'b0, kbd_rst_req = 1'b0;
  logic       busy, key_valid, err;
  logic [7:0] key;

  int         n_vec = 0, n_err = 0;
  int         kv_cnt;
  logic [7:0] kv_last;

  assign ps2_clk_in  = ~(ps2_clk_oe | kbd_clk_pull);
  assign ps2_data_in = ~(ps2_data_oe | kbd_data_pull);

  ps2_cmd_ctrl #(
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GRD), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .rx_key(rx_key), .rx_valid(rx_valid), .leds(leds),
    .led_req(led_req), .kbd_rst_req(kbd_rst_req),
    .busy(busy), .key(key), .key_valid(key_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_valid) begin
      kv_cnt  <= kv_cnt + 1;
      kv_last <= key;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_key   = b;
    rx_valid = 1'b1;
    tick(4);
    rx_valid = 1'b0;
    tick(4);
  endtask

  task automatic pulse_led;
    led_req = 1'b1;
    tick(1);
    led_req = 1'b0;
  endtask

  // Waits for the inhibit phase to end; optionally checks its length.
  task automatic wait_rts(input bit chk_inh, input string tag);
    int t = 0;
    int cnt = 0;
    while (!ps2_clk_oe && t < 20000) begin tick(1); t++; end
    while (ps2_clk_oe && t < 20000) begin tick(1); t++; cnt++; end
    chk({tag, "_rts"}, {31'b0, (t < 20000) && ps2_data_oe}, 32'd1);
    if (chk_inh) chk({tag, "_inhibit_len"}, cnt, INH);
  endtask

  // Device-generated clock: bits are read at the end of each low half.
  task automatic kbd_frame(input bit ack, input int stop_after,
                           output logic [7:0] b, output logic par, output logic stp);
    b = 8'h00; par = 1'b0; stp = 1'b0;
    tick(20);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin kbd_data_pull = 1'b1; tick(H); end
      kbd_clk_pull = 1'b1;
      tick(H);
      if (k == stop_after) return;
      if (k <= 8) b[k-1] = ps2_data_in;
      else if (k == 9) par = ps2_data_in;
      else if (k == 10) stp = ps2_data_in;
      kbd_clk_pull = 1'b0;
      tick(H);
    end
    kbd_data_pull = 1'b0;
  endtask

  task automatic do_byte(input string tag, input logic [7:0] exp_b, input logic exp_p,
                         input bit chk_inh, input logic [7:0] reply, input bit inject);
    logic [7:0] b;
    logic p, s;
    int kv0;
    wait_rts(chk_inh, tag);
    kbd_frame(1'b1, 0, b, p, s);
    chk({tag, "_byte"}, b, exp_b);
    chk({tag, "_parity"}, p, exp_p);
    chk({tag, "_stop"}, s, 1);
    kv0 = kv_cnt;
    send_rx(exp_b);  // receiver's copy of the host frame, inside the guard window
    chk({tag, "_guard_drop"}, kv_cnt, kv0);
    tick(GRD);
    if (inject) begin
      send_rx(8'h1C);
      chk({tag, "_wait_fwd_cnt"}, kv_cnt, kv0 + 1);
      chk({tag, "_wait_fwd_key"}, kv_last, 8'h1C);
      kv0 = kv0 + 1;
    end
    send_rx(reply);
    chk({tag, "_reply_hidden"}, kv_cnt, kv0);
  endtask

  initial begin
    logic [7:0] b;
    logic p, s;
    int kv0;

    // reset state
    tick(3);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key", key, 8'h00);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick(2);

    // LED update 3'b101: ED (six ones, parity 1) then 05 (parity 1)
    kv0 = kv_cnt;
    leds = 3'b101;
    pulse_led();
    chk("t1_busy_1cyc", busy, 1);
    tick(1);
    leds = 3'b000;  // already sampled at acceptance
    do_byte("t1_b0", 8'hED, 1'b1, 1'b1, 8'hFA, 1'b0);
    chk("t1_busy_mid", busy, 1);
    do_byte("t1_b1", 8'h05, 1'b1, 1'b0, 8'hFA, 1'b0);
    chk("t1_busy_done", busy, 0);
    chk("t1_err", err, 0);
    chk("t1_no_keys", kv_cnt, kv0);

    // simultaneous reset and LED requests: FF first
    leds = 3'b010;
    kbd_rst_req = 1'b1; led_req = 1'b1;
    tick(1);
    kbd_rst_req = 1'b0; led_req = 1'b0;
    do_byte("t2_b0", 8'hFF, 1'b1, 1'b0, 8'hFA, 1'b0);
    chk("t2_busy_mid", busy, 1);
    do_byte("t2_b1", 8'hED, 1'b1, 1'b0, 8'hFA, 1'b0);
    do_byte("t2_b2", 8'h02, 1'b0, 1'b0, 8'hFA, 1'b0);
    chk("t2_busy_done", busy, 0);

    // NACK on first ED, resent once
    leds = 3'b111;
    pulse_led();
    do_byte("t3_b0", 8'hED, 1'b1, 1'b0, 8'hFE, 1'b0);
    do_byte("t3_b0r", 8'hED, 1'b1, 1'b0, 8'hFA, 1'b0);
    do_byte("t3_b1", 8'h07, 1'b0, 1'b0, 8'hFA, 1'b0);
    chk("t3_err", err, 0);
    chk("t3_busy_done", busy, 0);

    // never line-acked: four attempts then err
    leds = 3'b001;
    pulse_led();
    for (int a = 0; a < 4; a++) begin
      wait_rts(1'b0, "t4_try");
      kbd_frame(1'b0, 0, b, p, s);
      chk("t4_try_byte", b, 8'hED);
    end
    tick(50);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_no_5th_try", ps2_clk_oe, 0);
    pulse_led();
    tick(1);
    chk("t4_err_cleared", err, 0);
    do_byte("t4_b0", 8'hED, 1'b1, 1'b0, 8'hFA, 1'b0);
    do_byte("t4_b1", 8'h01, 1'b0, 1'b0, 8'hFA, 1'b0);
    chk("t4_busy_done", busy, 0);

    // idle scancode forwarding with 3-cycle latency
    kv0 = kv_cnt;
    rx_key = 8'h1C;
    rx_valid = 1'b1;
    tick(2);
    chk("t5_kv_early", key_valid, 0);
    tick(1);
    chk("t5_kv_pulse", key_valid, 1);
    chk("t5_key", key, 8'h1C);
    tick(1);
    chk("t5_kv_one_cycle", key_valid, 0);
    rx_valid = 1'b0;
    tick(4);
    chk("t5_kv_count", kv_cnt, kv0 + 1);
    pulse_led();
    do_byte("t5_b0", 8'hED, 1'b1, 1'b0, 8'hFA, 1'b1);
    do_byte("t5_b1", 8'h01, 1'b0, 1'b0, 8'hFA, 1'b0);
    chk("t5_busy_done", busy, 0);

    // reset while data bit 4 of ED (a zero) is being driven
    leds = 3'b101;
    pulse_led();
    wait_rts(1'b0, "t6");
    kbd_frame(1'b1, 5, b, p, s);
    chk("t6_bit4_driven", ps2_data_oe, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_clk_oe", ps2_clk_oe, 0);
    chk("t6_rst_data_oe", ps2_data_oe, 0);
    chk("t6_rst_busy", busy, 0);
    kbd_clk_pull = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    pulse_led();
    do_byte("t6_b0", 8'hED, 1'b1, 1'b0, 8'hFA, 1'b0);
    do_byte("t6_b1", 8'h05, 1'b1, 1'b0, 8'hFA, 1'b0);
    chk("t6_busy_done", busy, 0);
    chk("t6_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
